// File: rtl/clk_disp_pkg.sv
// Shared types and constants for the time display path: converter states,
// digit codes, segment patterns and the shift-add-3 step.
package clk_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    // Everything that selects what is on the display; a change restarts conversion.
    typedef struct packed {
        logic [4:0] h;
        logic [5:0] m;
        logic       alarm;
    } src_key_t;

    localparam logic [3:0] DIGIT_DASH  = 4'hA;
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Active-high {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // One double-dabble iteration on {tens, units, 6-bit binary}.
    function automatic logic [13:0] dd_step(input logic [13:0] s);
        logic [13:0] t;
        t = s;
        if (t[13:10] >= 4'd5) t[13:10] = t[13:10] + 4'd3;
        if (t[9:6] >= 4'd5)   t[9:6]   = t[9:6] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-high 7-segment pattern; unknown codes light nothing.
module seg7_decode
    import clk_disp_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:       o_seg = SEG_0;
            4'd1:       o_seg = SEG_1;
            4'd2:       o_seg = SEG_2;
            4'd3:       o_seg = SEG_3;
            4'd4:       o_seg = SEG_4;
            4'd5:       o_seg = SEG_5;
            4'd6:       o_seg = SEG_6;
            4'd7:       o_seg = SEG_7;
            4'd8:       o_seg = SEG_8;
            4'd9:       o_seg = SEG_9;
            DIGIT_DASH: o_seg = SEG_DASH;
            default:    o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/time_display_ctrl.sv
// Binary HH:MM (time or alarm) to BCD via a sequential shift-add-3 engine,
// scanned onto a 4-digit multiplexed 7-segment display with a blinking separator.
module time_display_ctrl
    import clk_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 4,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit AN_ACT_LOW  = 1'b1
) (
    input  logic       slw_clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic [5:0] alarm_minutes,
    input  logic [4:0] alarm_hours,
    input  logic       show_alarm,
    input  logic       blank,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy,
    output logic       bcd_valid
);

    localparam int            PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic          DP_OFF  = SEG_ACT_LOW;
    localparam logic [3:0]    AN_OFF  = AN_ACT_LOW ? 4'hF : 4'h0;

    logic [4:0] w_src_h;
    logic [5:0] w_src_m;
    src_key_t   w_key;

    assign w_src_h = show_alarm ? alarm_hours : hours;
    assign w_src_m = show_alarm ? alarm_minutes : minutes;
    assign w_key   = {w_src_h, w_src_m, show_alarm};

    conv_state_t     r_state;
    src_key_t        r_key;
    logic [13:0]     r_sh_h;
    logic [13:0]     r_sh_m;
    logic [2:0]      r_iter;
    logic            r_h_bad;
    logic            r_m_bad;
    logic [3:0][3:0] r_dig;
    logic            r_busy;
    logic            r_bcd_valid;

    // Digits only change in COMMIT, so the scan never sees a partial result.
    always_ff @(posedge slw_clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_key       <= '0;
            r_sh_h      <= '0;
            r_sh_m      <= '0;
            r_iter      <= '0;
            r_h_bad     <= 1'b0;
            r_m_bad     <= 1'b0;
            r_dig       <= '0;
            r_busy      <= 1'b0;
            r_bcd_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_bcd_valid || (w_key != r_key)) begin
                        r_key   <= w_key;
                        r_sh_h  <= {8'd0, 1'b0, w_src_h};
                        r_sh_m  <= {8'd0, w_src_m};
                        r_h_bad <= (w_src_h > 5'd23);
                        r_m_bad <= (w_src_m > 6'd59);
                        r_iter  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_sh_h <= dd_step(r_sh_h);
                    r_sh_m <= dd_step(r_sh_m);
                    if (r_iter == 3'd5) r_state <= COMMIT;
                    else                r_iter  <= r_iter + 3'd1;
                end
                COMMIT: begin
                    r_dig[3]    <= r_h_bad ? DIGIT_DASH : r_sh_h[13:10];
                    r_dig[2]    <= r_h_bad ? DIGIT_DASH : r_sh_h[9:6];
                    r_dig[1]    <= r_m_bad ? DIGIT_DASH : r_sh_m[13:10];
                    r_dig[0]    <= r_m_bad ? DIGIT_DASH : r_sh_m[9:6];
                    r_bcd_valid <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [PW-1:0] r_pre;
    logic [1:0]    r_idx;
    logic          r_phase;

    always_ff @(posedge slw_clk or posedge rst) begin
        if (rst) begin
            r_pre   <= '0;
            r_idx   <= '0;
            r_phase <= 1'b0;
        end else if (r_pre == PRE_MAX) begin
            r_pre <= '0;
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) r_phase <= ~r_phase;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    logic [6:0] w_pat;
    logic [3:0] w_onehot;
    logic       w_on;
    logic       w_dp_on;

    seg7_decode u_dec (
        .i_digit (r_dig[r_idx]),
        .o_seg   (w_pat)
    );

    assign w_onehot = 4'b0001 << r_idx;
    assign w_on     = !blank && r_bcd_valid;
    // Separator blinks for the clock, stays lit while showing the alarm.
    assign w_dp_on  = w_on && (r_idx == 2'd2) && (show_alarm || r_phase);

    logic [6:0] r_seg;
    logic       r_dp;
    logic [3:0] r_an;

    always_ff @(posedge slw_clk or posedge rst) begin
        if (rst) begin
            r_seg <= SEG_OFF;
            r_dp  <= DP_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= w_on ? (SEG_ACT_LOW ? ~w_pat : w_pat) : SEG_OFF;
            r_an  <= w_on ? (AN_ACT_LOW ? ~w_onehot : w_onehot) : AN_OFF;
            r_dp  <= w_dp_on ? ~DP_OFF : DP_OFF;
        end
    end

    assign seg       = r_seg;
    assign dp        = r_dp;
    assign an        = r_an;
    assign busy      = r_busy;
    assign bcd_valid = r_bcd_valid;

endmodule

// File: tb/tb_time_display_ctrl.sv
// Directed bench for time_display_ctrl (SCAN_DIV=4, active-low seg/dp/an).
module tb_time_display_ctrl;

    logic       slw_clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] minutes = 6'd0;
    logic [4:0] hours = 5'd0;
    logic [5:0] alarm_minutes = 6'd0;
    logic [4:0] alarm_hours = 5'd0;
    logic       show_alarm = 1'b0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;
    logic       bcd_valid;

    int n_cmp = 0;
    int n_fail = 0;
    int dpa, dpb;

    always #5 slw_clk = ~slw_clk;

    time_display_ctrl #(
        .SCAN_DIV    (4),
        .SEG_ACT_LOW (1'b1),
        .AN_ACT_LOW  (1'b1)
    ) dut (
        .slw_clk       (slw_clk),
        .rst           (rst),
        .minutes       (minutes),
        .hours         (hours),
        .alarm_minutes (alarm_minutes),
        .alarm_hours   (alarm_hours),
        .show_alarm    (show_alarm),
        .blank         (blank),
        .seg           (seg),
        .dp            (dp),
        .an            (an),
        .busy          (busy),
        .bcd_valid     (bcd_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Busy for exactly 7 cycles after the capture edge, then a committed result.
    task automatic conv_latency(input string tag, input logic v_during);
        @(negedge slw_clk);
        chk({tag, "_busy_first"}, busy, 1'b1);
        chk({tag, "_valid_during"}, bcd_valid, v_during);
        repeat (6) begin
            @(negedge slw_clk);
            chk({tag, "_busy"}, busy, 1'b1);
        end
        @(negedge slw_clk);
        chk({tag, "_busy_done"}, busy, 1'b0);
        chk({tag, "_valid_done"}, bcd_valid, 1'b1);
    endtask

    // Wait for a fresh start of a scan round (an just became 1110).
    task automatic wait_an0(input string tag);
        logic [3:0] prev;
        bit found;
        prev  = an;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge slw_clk);
            if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = an;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s_wait_an0: observed timeout expected an=1110", tag);
        end
    endtask

    // One full scan round; returns how many cycles dp was lit on digit 2.
    task automatic check_round(input string tag, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0, output int dpc);
        logic [6:0] e [4];
        logic [3:0] ea;
        e[0] = s0; e[1] = s1; e[2] = s2; e[3] = s3;
        dpc = 0;
        wait_an0(tag);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (d != 0 || c != 0) @(negedge slw_clk);
                ea = 4'b0001 << d;
                ea = ~ea;
                chk({tag, "_an"}, an, ea);
                chk({tag, "_seg"}, seg, e[d]);
                if (d == 2) begin
                    if (dp == 1'b0) dpc++;
                end else begin
                    chk({tag, "_dp_off"}, dp, 1'b1);
                end
            end
        end
    endtask

    function automatic logic [6:0] exp_for_an(input logic [3:0] a, input logic [6:0] s3,
                                              input logic [6:0] s2, input logic [6:0] s1,
                                              input logic [6:0] s0);
        case (a)
            4'b1110: return s0;
            4'b1101: return s1;
            4'b1011: return s2;
            4'b0111: return s3;
            default: return 7'h7F;
        endcase
    endfunction

    initial begin
        // 1: reset state, first conversion of 00:00
        @(negedge slw_clk);
        @(negedge slw_clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", bcd_valid, 1'b0);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1'b1);
        rst = 1'b0;
        conv_latency("t1", 1'b0);
        check_round("t1_r", 7'h40, 7'h40, 7'h40, 7'h40, dpa);

        // 2: 23:59, separator blinks on alternate rounds
        @(negedge slw_clk);
        hours = 5'd23; minutes = 6'd59;
        conv_latency("t2", 1'b1);
        check_round("t2_ra", 7'h24, 7'h30, 7'h12, 7'h10, dpa);
        check_round("t2_rb", 7'h24, 7'h30, 7'h12, 7'h10, dpb);
        chk("t2_dp_alternate", ((dpa + dpb == 4) && (dpa == 0 || dpb == 0)), 1'b1);

        // 3: minutes out of range -> dashes on the minutes field
        @(negedge slw_clk);
        hours = 5'd7; minutes = 6'd60;
        conv_latency("t3", 1'b1);
        check_round("t3_r", 7'h40, 7'h78, 7'h3F, 7'h3F, dpa);

        // 4: input change mid-SHIFT is ignored until the next IDLE compare
        @(negedge slw_clk);
        hours = 5'd12; minutes = 6'd10;
        @(negedge slw_clk);
        chk("t4_busy_s0", busy, 1'b1);
        @(negedge slw_clk);
        chk("t4_busy_s1", busy, 1'b1);
        minutes = 6'd11;
        repeat (5) begin
            @(negedge slw_clk);
            chk("t4_busy_a", busy, 1'b1);
        end
        @(negedge slw_clk);
        chk("t4_gap_busy", busy, 1'b0);
        chk("t4_gap_valid", bcd_valid, 1'b1);
        repeat (7) begin
            @(negedge slw_clk);
            chk("t4_busy_b", busy, 1'b1);
            chk("t4_first_commit_seg", seg, exp_for_an(an, 7'h79, 7'h24, 7'h79, 7'h40));
        end
        @(negedge slw_clk);
        chk("t4_busy_end", busy, 1'b0);
        check_round("t4_r", 7'h79, 7'h24, 7'h79, 7'h79, dpa);

        // 5: alarm view 06:30, separator steady
        @(negedge slw_clk);
        alarm_hours = 5'd6; alarm_minutes = 6'd30; show_alarm = 1'b1;
        conv_latency("t5", 1'b1);
        check_round("t5_ra", 7'h40, 7'h02, 7'h30, 7'h40, dpa);
        check_round("t5_rb", 7'h40, 7'h02, 7'h30, 7'h40, dpb);
        chk("t5_dp_steady_a", dpa, 4);
        chk("t5_dp_steady_b", dpb, 4);

        // 6: blank while converting, then reset mid-SHIFT
        @(negedge slw_clk);
        blank = 1'b1; show_alarm = 1'b0;
        @(negedge slw_clk);
        chk("t6_blank_an", an, 4'hF);
        chk("t6_blank_busy", busy, 1'b1);
        repeat (6) begin
            @(negedge slw_clk);
            chk("t6_blank_an_hold", an, 4'hF);
            chk("t6_blank_busy_hold", busy, 1'b1);
        end
        @(negedge slw_clk);
        chk("t6_blank_done_busy", busy, 1'b0);
        chk("t6_blank_done_valid", bcd_valid, 1'b1);
        chk("t6_blank_done_an", an, 4'hF);
        chk("t6_blank_done_seg", seg, 7'h7F);
        blank = 1'b0; hours = 5'd13;
        @(negedge slw_clk);
        chk("t6_unblank_lit", (an != 4'hF), 1'b1);
        chk("t6_conv_busy0", busy, 1'b1);
        @(negedge slw_clk);
        chk("t6_conv_busy1", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", bcd_valid, 1'b0);
        chk("t6_rst_an", an, 4'hF);
        chk("t6_rst_seg", seg, 7'h7F);
        chk("t6_rst_dp", dp, 1'b1);
        @(negedge slw_clk);
        chk("t6_rst_hold_an", an, 4'hF);
        rst = 1'b0;
        conv_latency("t6_post", 1'b0);
        check_round("t6_r", 7'h79, 7'h30, 7'h79, 7'h79, dpa);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
